// File: rtl/ahb_tgt_mem_pkg.sv
// Shared types and constants for the AHB memory-backed target.
package ahb_tgt_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } tgt_state_t;

  localparam logic [31:0] TGT_ERR_RDATA = 32'hBADD_ADD5;

  function automatic logic [31:0] tgt_offset(input logic [31:0] addr,
                                             input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/ahb_tgt_mem_if.sv
// Request/response bus between the AHB access point initiator and the memory target.
interface ahb_tgt_mem_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        request_stall;
  logic        error;

  modport master (
    output ren, wen, addr, wdata, strobe,
    input  rdata, request_stall, error
  );

  modport slave (
    input  ren, wen, addr, wdata, strobe,
    output rdata, request_stall, error
  );
endinterface

// File: rtl/ahb_tgt_mem_ram.sv
// DEPTH_WORDS x 32 storage: synchronous clear, byte-lane write, registered read.
module ahb_tgt_ram #(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        for (int unsigned b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (re) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/ahb_tgt_mem.sv
// Memory-backed bus target with programmable wait states.
// Optional range checking with error response: define AHB_TGT_ERR_EN.
module ahb_tgt_mem
  import ahb_tgt_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_8000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          AFT_CLK,
  input  logic          nRST,
  ahb_tgt_mem_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  tgt_state_t       state;
  logic [3:0]       cnt;
  logic             cap_wr;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_strobe;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_oor;
  logic [31:0]      offset;
  logic             req;
  logic             ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata;

  assign req    = bus.ren | bus.wen;
  assign offset = tgt_offset(bus.addr, ADDR_BASE);

  always_ff @(posedge AFT_CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_wr     <= 1'b0;
      cap_wdata  <= '0;
      cap_strobe <= '0;
      cap_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_wr     <= bus.wen;
            cap_wdata  <= bus.wdata;
            cap_strobe <= bus.strobe;
            cap_idx    <= IDX_W'(offset >> 2);
            cnt        <= 4'(WAIT_STATES);
            state      <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // a withdrawn request aborts the access without touching storage
          if (!req)              state <= IDLE;
          else if (cnt == 4'd1)  state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_we = (state == RESP) &&  cap_wr && !cap_oor;
  assign ram_re = (state == RESP) && !cap_wr;

  ahb_tgt_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (AFT_CLK),
    .rst_n (nRST),
    .we    (ram_we),
    .re    (ram_re),
    .be    (cap_strobe),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  assign bus.request_stall = nRST && req && (state != RESP);

`ifdef AHB_TGT_ERR_EN
  logic err_rd_q;

  // err_rd_q tracks whether the last completed read was out of range
  always_ff @(posedge AFT_CLK) begin
    if (!nRST) begin
      cap_oor  <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      if (state == IDLE && req) cap_oor <= (offset >= 32'(4 * DEPTH_WORDS));
      if (ram_re)               err_rd_q <= cap_oor;
    end
  end

  assign bus.rdata = err_rd_q ? TGT_ERR_RDATA : ram_rdata;
  assign bus.error = nRST && (state == RESP) && cap_oor;
`else
  assign cap_oor   = 1'b0;
  assign bus.rdata = ram_rdata;
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_tgt_mem.sv
// Self-checking bench for ahb_tgt_mem: three instances (2, 0, 3 wait states) against a transaction model.
module tb_ahb_tgt_mem;

  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam logic [31:0] ERRV = 32'hBADD_ADD5;
  localparam int WSV [3] = '{2, 0, 3};
`ifdef AHB_TGT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst_d   [3];
  logic        ren_d    [3];
  logic        wen_d    [3];
  logic [31:0] addr_d   [3];
  logic [31:0] wdata_d  [3];
  logic [3:0]  strobe_d [3];
  logic [31:0] rdata_o  [3];
  logic        stall_o  [3];
  logic        err_o    [3];

  for (genvar g = 0; g < 3; g++) begin : u
    ahb_tgt_mem_if bus ();
    assign bus.ren    = ren_d[g];
    assign bus.wen    = wen_d[g];
    assign bus.addr   = addr_d[g];
    assign bus.wdata  = wdata_d[g];
    assign bus.strobe = strobe_d[g];
    assign rdata_o[g] = bus.rdata;
    assign stall_o[g] = bus.request_stall;
    assign err_o[g]   = bus.error;

    ahb_tgt_mem #(.ADDR_BASE(BASE), .DEPTH_WORDS(64), .WAIT_STATES(WSV[g])) dut (
      .AFT_CLK (clk),
      .nRST    (nrst_d[g]),
      .bus     (bus)
    );
  end

  // transaction-level model
  logic [31:0] mem_m [3][64];
  logic [31:0] rdm   [3];
  bit          exp_v     [3];
  logic        exp_stall [3];
  logic        exp_err   [3];
  logic [31:0] exp_rdata [3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (exp_v[d]) begin
        check($sformatf("stall[%0d]", d), 32'(stall_o[d]), 32'(exp_stall[d]));
        check($sformatf("error[%0d]", d), 32'(err_o[d]),   32'(exp_err[d]));
        check($sformatf("rdata[%0d]", d), rdata_o[d],      exp_rdata[d]);
      end
    end
  end

  function automatic int midx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o >> 2) % 64);
  endfunction

  function automatic bit oor(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o >= 32'd256;
  endfunction

  function automatic void clear_model(input int d);
    for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
    rdm[d] = '0;
  endfunction

  // op: 0 read, 1 write, 2 ren+wen (write). Caller sits #1 after a posedge.
  task automatic do_txn(input int d, input int op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input bit drop);
    bit wr, e;
    int ix;
    wr = (op != 0);
    ix = midx(a);
    e  = ERR_EN && oor(a);
    ren_d[d] = (op != 1); wen_d[d] = wr;
    addr_d[d] = a; wdata_d[d] = wd; strobe_d[d] = st;
    exp_stall[d] = 1'b1; exp_err[d] = 1'b0; exp_rdata[d] = rdm[d];
    for (int k = 0; k <= WSV[d]; k++) begin
      @(posedge clk); #1;
      addr_d[d] = a ^ 32'h40; wdata_d[d] = ~wd; strobe_d[d] = ~st;
      if (drop) begin
        ren_d[d] = 1'b0; wen_d[d] = 1'b0; exp_stall[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      exp_stall[d] = (k < WSV[d]);
      exp_err[d]   = (k == WSV[d]) ? e : 1'b0;
    end
    @(posedge clk); #1;
    if (wr) begin
      if (!e)
        for (int b = 0; b < 4; b++)
          if (st[b]) mem_m[d][ix][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rdm[d] = e ? ERRV : mem_m[d][ix];
    end
    ren_d[d] = 1'b0; wen_d[d] = 1'b0;
    exp_stall[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = rdm[d];
    @(posedge clk); #1;
  endtask

  task automatic reset_mid(input int d, input logic [31:0] a);
    ren_d[d] = 1'b1; wen_d[d] = 1'b0; addr_d[d] = a;
    exp_stall[d] = 1'b1;
    @(posedge clk); #1;
    nrst_d[d] = 1'b0; exp_stall[d] = 1'b0;
    @(posedge clk); #1;
    clear_model(d);
    exp_rdata[d] = '0;
    nrst_d[d] = 1'b1; ren_d[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      nrst_d[d] = 1'b0; ren_d[d] = 1'b0; wen_d[d] = 1'b0;
      addr_d[d] = '0; wdata_d[d] = '0; strobe_d[d] = '0;
      exp_v[d] = 1'b0; exp_stall[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = '0;
      clear_model(d);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) exp_v[d] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) nrst_d[d] = 1'b1;
    @(posedge clk); #1;

    // two wait states: first read, lane merge, null strobe, ren+wen, boundary alias
    do_txn(0, 0, 32'h8000, '0, 4'h0, 1'b0);
    check("pin_rd0", rdata_o[0], 32'h0);
    do_txn(0, 1, 32'h8004, 32'hDEADBEEF, 4'hF, 1'b0);
    do_txn(0, 1, 32'h8004, 32'h000000AA, 4'b0001, 1'b0);
    do_txn(0, 0, 32'h8004, '0, 4'h0, 1'b0);
    check("pin_beaa", rdata_o[0], 32'hDEADBEAA);
    check("pin_model_beaa", rdm[0], 32'hDEADBEAA);
    do_txn(0, 1, 32'h8004, 32'h12345678, 4'h0, 1'b0);
    do_txn(0, 0, 32'h8004, '0, 4'h0, 1'b0);
    check("pin_strb0", rdata_o[0], 32'hDEADBEAA);
    do_txn(0, 2, 32'h8010, 32'hCAFEF00D, 4'b1010, 1'b0);
    do_txn(0, 0, 32'h8010, '0, 4'h0, 1'b0);
    check("pin_renwen", rdata_o[0], 32'hCA00F000);
    do_txn(0, 1, 32'h80FC, 32'hA5A5A5A5, 4'hF, 1'b0);
    do_txn(0, 0, 32'h7FFC, '0, 4'h0, 1'b0);
`ifdef AHB_TGT_ERR_EN
    check("pin_below_base", rdata_o[0], 32'hBADDADD5);
`else
    check("pin_below_base", rdata_o[0], 32'hA5A5A5A5);
`endif

    // zero wait states: back-to-back writes/reads, out-of-range alias or error
    do_txn(1, 1, 32'h8008, 32'h11223344, 4'hF, 1'b0);
    do_txn(1, 1, 32'h800C, 32'h55667788, 4'hF, 1'b0);
    do_txn(1, 0, 32'h8008, '0, 4'h0, 1'b0);
    check("pin_ws0_a", rdata_o[1], 32'h11223344);
    do_txn(1, 0, 32'h800C, '0, 4'h0, 1'b0);
    check("pin_ws0_b", rdata_o[1], 32'h55667788);
    do_txn(1, 1, 32'h8000, 32'h0F0F0F0F, 4'hF, 1'b0);
    do_txn(1, 1, 32'h9000, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_txn(1, 0, 32'h9000, '0, 4'h0, 1'b0);
`ifdef AHB_TGT_ERR_EN
    check("pin_oor_rd", rdata_o[1], 32'hBADDADD5);
`else
    check("pin_oor_rd", rdata_o[1], 32'hFFFFFFFF);
`endif
    do_txn(1, 0, 32'h8000, '0, 4'h0, 1'b0);
`ifdef AHB_TGT_ERR_EN
    check("pin_word0", rdata_o[1], 32'h0F0F0F0F);
`else
    check("pin_word0", rdata_o[1], 32'hFFFFFFFF);
`endif

    // three wait states: aborted read leaves rdata alone, FSM free at cycle 2
    do_txn(2, 1, 32'h8020, 32'h13579BDF, 4'hF, 1'b0);
    do_txn(2, 0, 32'h8020, '0, 4'h0, 1'b0);
    do_txn(2, 0, 32'h8024, '0, 4'h0, 1'b1);
    check("pin_abort_hold", rdata_o[2], 32'h13579BDF);
    do_txn(2, 0, 32'h8010, '0, 4'h0, 1'b0);
    check("pin_after_abort", rdata_o[2], 32'h0);

    // reset while waiting clears storage
    reset_mid(0, 32'h8004);
    check("pin_rst_rdata", rdata_o[0], 32'h0);
    for (int i = 0; i < 64; i++)
      do_txn(0, 0, BASE + 32'(4 * i), '0, 4'h0, 1'b0);
    check("pin_model_clr", mem_m[0][1], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
